// File: rtl/linebuf_pkg.sv
// Shared types for the line-buffer sequencer: FSM state encoding and a saturating
// increment used by the row and fill counters.
package linebuf_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_VBLANK = 2'd1,
        S_LINE   = 2'd2,
        S_HBLANK = 2'd3
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/linebuf_sync_edge_det.sv
// Registers dv/hs/vs once and derives the vsync rising edge and data-valid falling edge.
// Latency 1 cycle for the registered copies; pulses are combinational on the live inputs.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic dv_i,
    input  logic hs_i,
    input  logic vs_i,
    output logic dv_q_o,
    output logic hs_q_o,
    output logic vs_q_o,
    output logic vs_rise_o,
    output logic dv_fall_o
);

    logic dv_q;
    logic hs_q;
    logic vs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            dv_q <= dv_i;
            hs_q <= hs_i;
            vs_q <= vs_i;
        end
    end

    assign dv_q_o    = dv_q;
    assign hs_q_o    = hs_q;
    assign vs_q_o    = vs_q;
    assign vs_rise_o = vs_i & ~vs_q;
    assign dv_fall_o = ~dv_i & dv_q;

endmodule

// File: rtl/linebuf_ctrl.sv
// Line-buffer sequencer: column/row tracking, line-RAM addressing and 2-cycle sync alignment.
// Optional LINEBUF_ROWMASK_EN qualifies row taps so previous-frame rows are never flagged valid.
module linebuf_ctrl
    import linebuf_pkg::*;
#(
    parameter int SCREENWIDTH = 1600,
    parameter int ADDR_W      = 11,
    parameter int ROW_W       = 11,
    parameter int BUF_DEPTH   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dv_i,
    input  logic                 hs_i,
    input  logic                 vs_i,
    output logic [ADDR_W-1:0]    rd_addr_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic                 ram_en_o,
    output logic                 ram_we_o,
    output logic [ADDR_W-1:0]    col_o,
    output logic [ROW_W-1:0]     row_o,
    output logic [BUF_DEPTH-1:0] row_mask_o,
    output logic                 win_vld_o,
    output logic                 dv_o,
    output logic                 hs_o,
    output logic                 vs_o,
    output logic                 err_o
);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(SCREENWIDTH - 1);
    localparam logic [31:0]       ROW_MAX  = 32'((1 << ROW_W) - 1);

    logic dv_q;
    logic hs_q;
    logic vs_q;
    logic vs_rise;
    logic eol;

    sync_edge_det u_edge (
        .clk       (clk),
        .rst       (rst),
        .dv_i      (dv_i),
        .hs_i      (hs_i),
        .vs_i      (vs_i),
        .dv_q_o    (dv_q),
        .hs_q_o    (hs_q),
        .vs_q_o    (vs_q),
        .vs_rise_o (vs_rise),
        .dv_fall_o (eol)
    );

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                lim_q, lim_d;
    logic                err_q, err_d;
    logic                ovf_p1_q, ovf_p2_q;
    logic [2:0]          sync_p2_q;
    logic                ovf;
    logic                line_act;
    logic                line_end;

    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            state_d = S_VBLANK;
        end else begin
            case (state_q)
                S_WAIT:   state_d = S_WAIT;
                S_VBLANK: if (dv_i) state_d = S_LINE;
                S_LINE:   if (eol)  state_d = S_HBLANK;
                S_HBLANK: if (dv_i) state_d = S_LINE;
                default:  state_d = S_WAIT;
            endcase
        end
    end

    // lim_q marks that the last legal column was already consumed; any further dv is overflow.
    always_comb begin
        col_d = '0;
        lim_d = 1'b0;
        if ((state_q != S_WAIT) && dv_i) begin
            if (col_q == COL_LAST) begin
                col_d = col_q;
                lim_d = 1'b1;
            end else begin
                col_d = col_q + ADDR_W'(1);
            end
        end
    end

    assign wr_addr_d = col_d - ADDR_W'(1);
    assign ovf       = dv_i & lim_q;

    // Only a line that ends inside the current frame counts; the tail of a line
    // cut by a mid-line vsync ends in S_VBLANK and is discarded.
    assign line_end  = eol & (state_q == S_LINE);

    always_comb begin
        row_d = row_q;
        if (vs_rise) begin
            row_d = '0;
        end else if (line_end) begin
            row_d = ROW_W'(sat_inc(32'(row_q), ROW_MAX));
        end
    end

    always_comb begin
        err_d = err_q | ovf;
        if (vs_rise) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_WAIT;
            col_q     <= '0;
            wr_addr_q <= '0;
            row_q     <= '0;
            lim_q     <= 1'b0;
            err_q     <= 1'b0;
            ovf_p1_q  <= 1'b0;
            ovf_p2_q  <= 1'b0;
            sync_p2_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            wr_addr_q <= wr_addr_d;
            row_q     <= row_d;
            lim_q     <= lim_d;
            err_q     <= err_d;
            ovf_p1_q  <= ovf;
            ovf_p2_q  <= ovf_p1_q;
            sync_p2_q <= {vs_q, hs_q, dv_q};
        end
    end

    assign line_act  = (state_q == S_LINE) || (state_q == S_HBLANK);

    assign dv_o      = sync_p2_q[0];
    assign hs_o      = sync_p2_q[1];
    assign vs_o      = sync_p2_q[2];
    assign rd_addr_o = col_q;
    assign wr_addr_o = wr_addr_q;
    assign col_o     = col_q;
    assign row_o     = row_q;
    assign err_o     = err_q;
    assign ram_en_o  = line_act & (dv_i | dv_o);
    // Overflow is delayed to line up with the write data leaving the 2-cycle pipeline.
    assign ram_we_o  = line_act & dv_o & ~ovf_p2_q;

`ifdef LINEBUF_ROWMASK_EN
    localparam int          FILL_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [31:0] FILL_MAX = 32'(BUF_DEPTH - 1);

    logic [FILL_W-1:0] filled_q, filled_d;
    logic [FILL_W-1:0] filled_p1_q, filled_p2_q;

    always_comb begin
        filled_d = filled_q;
        if (vs_rise) begin
            filled_d = '0;
        end else if (line_end) begin
            filled_d = FILL_W'(sat_inc(32'(filled_q), FILL_MAX));
        end
    end

    // The fill count is delayed alongside dv so the mask describes the pixel on dv_o.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filled_q    <= '0;
            filled_p1_q <= '0;
            filled_p2_q <= '0;
        end else begin
            filled_q    <= filled_d;
            filled_p1_q <= filled_q;
            filled_p2_q <= filled_p1_q;
        end
    end

    always_comb begin
        row_mask_o = '0;
        for (int k = 0; k < BUF_DEPTH; k++) begin
            row_mask_o[k] = dv_o & (32'(filled_p2_q) >= 32'(k));
        end
        win_vld_o = dv_o & (32'(filled_p2_q) == FILL_MAX);
    end
`else
    assign row_mask_o = {BUF_DEPTH{dv_o}};
    assign win_vld_o  = dv_o;
`endif

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Directed bench for linebuf_ctrl at default parameters (1600 px lines, 3 row taps).
module tb_linebuf_ctrl;

    logic        clk;
    logic        rst;
    logic        dv_i;
    logic        hs_i;
    logic        vs_i;
    logic [10:0] rd_addr_o;
    logic [10:0] wr_addr_o;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [10:0] col_o;
    logic [10:0] row_o;
    logic [2:0]  row_mask_o;
    logic        win_vld_o;
    logic        dv_o;
    logic        hs_o;
    logic        vs_o;
    logic        err_o;

    int errs;
    int checks;

    linebuf_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .dv_i       (dv_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .rd_addr_o  (rd_addr_o),
        .wr_addr_o  (wr_addr_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .col_o      (col_o),
        .row_o      (row_o),
        .row_mask_o (row_mask_o),
        .win_vld_o  (win_vld_o),
        .dv_o       (dv_o),
        .hs_o       (hs_o),
        .vs_o       (vs_o),
        .err_o      (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected tap mask for a pixel on dv_o when 'fills' lines of this frame are complete.
    function automatic logic [2:0] exp_mask(input int fills, input logic dvo);
`ifdef LINEBUF_ROWMASK_EN
        logic [2:0] m;
        m = (fills >= 2) ? 3'b111 : (fills == 1) ? 3'b011 : 3'b001;
        return dvo ? m : 3'b000;
`else
        return {3{dvo}};
`endif
    endfunction

    function automatic logic exp_win(input int fills, input logic dvo);
`ifdef LINEBUF_ROWMASK_EN
        return dvo & (fills >= 2);
`else
        return dvo;
`endif
    endfunction

    // One pixel period: inputs change just after the rising edge, outputs are read at the falling edge.
    task automatic step(input logic dv, input logic hs, input logic vs);
        @(posedge clk);
        #1;
        dv_i = dv;
        hs_i = hs;
        vs_i = vs;
        @(negedge clk);
    endtask

    task automatic plain_line(input int npx, input int nblank);
        for (int p = 0; p < npx; p++) step(1'b1, 1'b0, 1'b0);
        for (int h = 0; h < nblank; h++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [55:0] all_out;
        rst  = 1'b0;
        dv_i = 1'b1;
        hs_i = 1'b1;
        vs_i = 1'b1;
        repeat (3) @(negedge clk);
        all_out = {rd_addr_o, wr_addr_o, ram_en_o, ram_we_o, col_o, row_o, row_mask_o,
                   win_vld_o, dv_o, hs_o, vs_o, err_o};
        checks++;
        if (all_out !== '0) begin
            errs++;
            $display("FAIL reset_initial got=%h exp=0", all_out);
        end
        @(posedge clk);
        #1;
        rst  = 1'b1;
        dv_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        for (int p = 0; p <= 500; p++) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (col_o !== 11'd500) begin
            errs++;
            $display("FAIL reset_precol got=%0d exp=500", col_o);
        end
        #2;
        rst = 1'b0;
        #1;
        all_out = {rd_addr_o, wr_addr_o, ram_en_o, ram_we_o, col_o, row_o, row_mask_o,
                   win_vld_o, dv_o, hs_o, vs_o, err_o};
        checks++;
        if (all_out !== '0) begin
            errs++;
            $display("FAIL reset_midline got=%h exp=0", all_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if ({col_o, row_o, ram_en_o, ram_we_o, err_o, dv_o} !== {11'd0, 11'd0, 3'b000, (i >= 1)}) begin
                errs++;
                $display("FAIL reset_wait i=%0d got col=%0d row=%0d en=%b we=%b err=%b dv_o=%b exp dv_o=%b",
                         i, col_o, row_o, ram_en_o, ram_we_o, err_o, dv_o, (i >= 1));
            end
        end
        repeat (5) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lines();
        logic [32:0] exp_addr;
        logic        dvo;
        logic        en;
        logic        hs;
        int          we_cnt;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (vs_o !== (i == 1)) begin
                errs++;
                $display("FAIL vs_delay i=%0d got=%b exp=%b", i, vs_o, (i == 1));
            end
        end
        for (int n = 0; n < 3; n++) begin
            we_cnt = 0;
            for (int p = 0; p < 1600; p++) begin
                step(1'b1, 1'b0, 1'b0);
                exp_addr = {11'(p), 11'(p - 1), 11'(p)};
                dvo = (p >= 2);
                en  = !(n == 0 && p == 0);
                if (ram_we_o) we_cnt++;
                checks++;
                if ({rd_addr_o, wr_addr_o, col_o} !== exp_addr) begin
                    errs++;
                    $display("FAIL addr line=%0d px=%0d got=%h exp=%h", n, p, {rd_addr_o, wr_addr_o, col_o}, exp_addr);
                end
                checks++;
                if ({row_o, dv_o, ram_en_o, ram_we_o, row_mask_o, win_vld_o} !==
                    {11'(n), dvo, en, dvo, exp_mask(n, dvo), exp_win(n, dvo)}) begin
                    errs++;
                    $display("FAIL ctrl line=%0d px=%0d got row=%0d dv=%b en=%b we=%b mask=%b win=%b exp row=%0d dv=%b en=%b mask=%b win=%b",
                             n, p, row_o, dv_o, ram_en_o, ram_we_o, row_mask_o, win_vld_o,
                             n, dvo, en, exp_mask(n, dvo), exp_win(n, dvo));
                end
            end
            for (int h = 0; h < 200; h++) begin
                hs = (h >= 10 && h < 20);
                step(1'b0, hs, 1'b0);
                dvo = (h < 2);
                if (ram_we_o) we_cnt++;
                checks++;
                if ({dv_o, ram_en_o, ram_we_o, hs_o, row_mask_o} !==
                    {dvo, dvo, dvo, (h >= 12 && h < 22), exp_mask(n, dvo)}) begin
                    errs++;
                    $display("FAIL hblank line=%0d h=%0d got dv=%b en=%b we=%b hs=%b mask=%b",
                             n, h, dv_o, ram_en_o, ram_we_o, hs_o, row_mask_o);
                end
            end
            checks++;
            if (we_cnt != 1600 || row_o !== 11'(n + 1)) begin
                errs++;
                $display("FAIL line_total line=%0d got we=%0d row=%0d exp we=1600 row=%0d", n, we_cnt, row_o, n + 1);
            end
        end
    endtask

    task automatic test_overflow();
        int we_cnt;
        int exp_col;
        we_cnt = 0;
        step(1'b0, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 1700; p++) begin
            step(1'b1, 1'b0, 1'b0);
            exp_col = (p < 1599) ? p : 1599;
            if (ram_we_o) we_cnt++;
            checks++;
            if ({col_o, err_o} !== {11'(exp_col), (p >= 1601)}) begin
                errs++;
                $display("FAIL ovf px=%0d got col=%0d err=%b exp col=%0d err=%b", p, col_o, err_o, exp_col, (p >= 1601));
            end
        end
        for (int h = 0; h < 30; h++) begin
            step(1'b0, 1'b0, 1'b0);
            if (ram_we_o) we_cnt++;
        end
        checks++;
        if (we_cnt != 1600 || err_o !== 1'b1) begin
            errs++;
            $display("FAIL ovf_total got we=%0d err=%b exp we=1600 err=1", we_cnt, err_o);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (err_o !== 1'b1 || row_o !== 11'd1) begin
            errs++;
            $display("FAIL ovf_vs_edge got err=%b row=%0d exp err=1 row=1", err_o, row_o);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (err_o !== 1'b0 || row_o !== 11'd0) begin
            errs++;
            $display("FAIL ovf_clear got err=%b row=%0d exp err=0 row=0", err_o, row_o);
        end
    endtask

    task automatic test_restart();
        repeat (10) step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) plain_line(1600, 20);
        for (int p = 0; p <= 800; p++) step(1'b1, 1'b0, (p == 800));
        checks++;
        if ({col_o, row_o} !== {11'd800, 11'd5}) begin
            errs++;
            $display("FAIL restart_pre got col=%0d row=%0d exp col=800 row=5", col_o, row_o);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({row_o, ram_en_o, ram_we_o} !== {11'd0, 2'b00}) begin
            errs++;
            $display("FAIL restart_vblank got row=%0d en=%b we=%b exp row=0 en=0 we=0", row_o, ram_en_o, ram_we_o);
        end
        repeat (20) step(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 1600; p++) begin
            step(1'b1, 1'b0, 1'b0);
            if (p == 2) begin
                checks++;
                if ({row_o, row_mask_o, win_vld_o} !== {11'd0, exp_mask(0, 1'b1), exp_win(0, 1'b1)}) begin
                    errs++;
                    $display("FAIL restart_mask got row=%0d mask=%b win=%b exp row=0 mask=%b win=%b",
                             row_o, row_mask_o, win_vld_o, exp_mask(0, 1'b1), exp_win(0, 1'b1));
                end
            end
        end
        repeat (20) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (row_o !== 11'd1) begin
            errs++;
            $display("FAIL restart_row got=%0d exp=1", row_o);
        end
    endtask

    task automatic test_coincident();
        plain_line(1600, 0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (row_o !== 11'd0) begin
            errs++;
            $display("FAIL coinc_row got=%0d exp=0", row_o);
        end
        repeat (20) step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 2; n++) begin
            for (int p = 0; p < 1600; p++) begin
                step(1'b1, 1'b0, 1'b0);
                if (p == 0) begin
                    checks++;
                    if ({row_o, ram_en_o} !== {11'(n), (n != 0)}) begin
                        errs++;
                        $display("FAIL coinc_start line=%0d got row=%0d en=%b exp row=%0d en=%b",
                                 n, row_o, ram_en_o, n, (n != 0));
                    end
                end
                if (p == 2) begin
                    checks++;
                    if ({row_mask_o, win_vld_o} !== {exp_mask(n, 1'b1), exp_win(n, 1'b1)}) begin
                        errs++;
                        $display("FAIL coinc_mask line=%0d got mask=%b win=%b exp mask=%b win=%b",
                                 n, row_mask_o, win_vld_o, exp_mask(n, 1'b1), exp_win(n, 1'b1));
                    end
                end
            end
            repeat (20) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst    = 1'b0;
        dv_i   = 1'b0;
        hs_i   = 1'b0;
        vs_i   = 1'b0;
        test_reset();
        test_lines();
        test_overflow();
        test_restart();
        test_coincident();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
